// File: rtl/kernel_kcore_fifo_param_s.sv
// First-word-fall-through circular FIFO with registered status flags,
// occupancy output and sticky overflow/underflow error flags.
module kernel_kcore_fifo_param_s #(
    parameter int DATA_WIDTH    = 64,
    parameter int DEPTH         = 2,
    parameter int ADDR_WIDTH    = 1,
    parameter int AFULL_THRESH  = DEPTH - 1,
    parameter int AEMPTY_THRESH = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  if_write,
    input  logic                  if_write_ce,
    input  logic [DATA_WIDTH-1:0] if_din,
    output logic                  if_full_n,
    input  logic                  if_read,
    input  logic                  if_read_ce,
    output logic [DATA_WIDTH-1:0] if_dout,
    output logic                  if_empty_n,
    output logic [ADDR_WIDTH:0]   if_num_data_valid,
    output logic                  if_almost_full_n,
    output logic                  if_almost_empty_n,
    input  logic                  if_err_clr,
    output logic                  if_overflow,
    output logic                  if_underflow
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [CNT_W-1:0]      DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0]      AFULL_C  = CNT_W'(AFULL_THRESH);
    localparam logic [CNT_W-1:0]      AEMPTY_C = CNT_W'(AEMPTY_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [0:DEPTH-1];

    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  full_n_q, full_n_d;
    logic                  empty_n_q, empty_n_d;
    logic                  afull_n_q, afull_n_d;
    logic                  aempty_n_q, aempty_n_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic wr_req_s, rd_req_s, wr_acc_s, rd_acc_s;

    assign wr_req_s = if_write & if_write_ce;
    assign rd_req_s = if_read & if_read_ce;
    assign wr_acc_s = wr_req_s & full_n_q;
    assign rd_acc_s = rd_req_s & empty_n_q;

    // Next-state for pointers, occupancy, status and error flags.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;

        if (wr_acc_s) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + ADDR_WIDTH'(1);
        end else begin
            wr_ptr_d = wr_ptr_q;
        end

        if (rd_acc_s) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + ADDR_WIDTH'(1);
        end else begin
            rd_ptr_d = rd_ptr_q;
        end

        case ({wr_acc_s, rd_acc_s})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        // Flags are derived from the post-edge count so they track it exactly.
        full_n_d   = (count_d != DEPTH_C);
        empty_n_d  = (count_d != '0);
        afull_n_d  = (count_d < AFULL_C);
        aempty_n_d = (count_d > AEMPTY_C);

        overflow_d  = (wr_req_s & ~full_n_q)  | (overflow_q  & ~if_err_clr);
        underflow_d = (rd_req_s & ~empty_n_q) | (underflow_q & ~if_err_clr);
    end

    // Control and flag registers; reset overrides every request.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_n_q    <= 1'b1;
            empty_n_q   <= 1'b0;
            afull_n_q   <= 1'b1;
            aempty_n_q  <= 1'b0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_n_q    <= full_n_d;
            empty_n_q   <= empty_n_d;
            afull_n_q   <= afull_n_d;
            aempty_n_q  <= aempty_n_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage array; contents are not reset, pointers alone define validity.
    always_ff @(posedge clk) begin
        if (wr_acc_s && !reset) begin
            mem_q[wr_ptr_q] <= if_din;
        end
    end

    assign if_dout           = mem_q[rd_ptr_q];
    assign if_full_n         = full_n_q;
    assign if_empty_n        = empty_n_q;
    assign if_almost_full_n  = afull_n_q;
    assign if_almost_empty_n = aempty_n_q;
    assign if_num_data_valid = count_q;
    assign if_overflow       = overflow_q;
    assign if_underflow      = underflow_q;

endmodule

// File: tb/tb_kernel_kcore_fifo_param_s.sv
// Directed self-checking bench for kernel_kcore_fifo_param_s
// (DATA_WIDTH=8, DEPTH=5, AFULL_THRESH=4, AEMPTY_THRESH=1).
module tb_kernel_kcore_fifo_param_s;

    localparam int DW = 8;
    localparam int DP = 5;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          if_write, if_write_ce, if_read, if_read_ce, if_err_clr;
    logic [DW-1:0] if_din;
    logic [DW-1:0] if_dout;
    logic          if_full_n, if_empty_n, if_almost_full_n, if_almost_empty_n;
    logic          if_overflow, if_underflow;
    logic [AW:0]   if_num_data_valid;

    int checks_cnt = 0;
    int fail_cnt   = 0;

    kernel_kcore_fifo_param_s #(
        .DATA_WIDTH(DW), .DEPTH(DP), .ADDR_WIDTH(AW),
        .AFULL_THRESH(4), .AEMPTY_THRESH(1)
    ) dut (
        .clk(clk), .reset(reset),
        .if_write(if_write), .if_write_ce(if_write_ce), .if_din(if_din),
        .if_full_n(if_full_n),
        .if_read(if_read), .if_read_ce(if_read_ce), .if_dout(if_dout),
        .if_empty_n(if_empty_n), .if_num_data_valid(if_num_data_valid),
        .if_almost_full_n(if_almost_full_n), .if_almost_empty_n(if_almost_empty_n),
        .if_err_clr(if_err_clr), .if_overflow(if_overflow), .if_underflow(if_underflow)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks_cnt++;
        if (act !== exp) begin
            fail_cnt++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Advance one clock edge and settle just after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        if_write = 1'b0; if_read = 1'b0; if_err_clr = 1'b0;
        if_write_ce = 1'b1; if_read_ce = 1'b1;
    endtask

    initial begin
        reset = 1'b1; if_din = '0;
        idle();
        step(); step();
        reset = 1'b0;
        chk("rst_count",    32'(if_num_data_valid), 32'd0);
        chk("rst_empty_n",  32'(if_empty_n),        32'd0);
        chk("rst_full_n",   32'(if_full_n),         32'd1);
        chk("rst_aempty_n", 32'(if_almost_empty_n), 32'd0);
        chk("rst_afull_n",  32'(if_almost_full_n),  32'd1);
        chk("rst_ovf",      32'(if_overflow),       32'd0);
        chk("rst_unf",      32'(if_underflow),      32'd0);

        // Fill 0x11..0x15
        for (int i = 0; i < 5; i++) begin
            if_write = 1'b1; if_din = 8'(8'h11 + i);
            step();
            chk("fill_count",    32'(if_num_data_valid), 32'(i + 1));
            chk("fill_afull_n",  32'(if_almost_full_n),  32'((i + 1) < 4));
            chk("fill_full_n",   32'(if_full_n),         32'((i + 1) < 5));
            chk("fill_aempty_n", 32'(if_almost_empty_n), 32'((i + 1) > 1));
            if (i == 0) chk("fill_latency_dout", 32'(if_dout), 32'h11);
        end
        if_din = 8'h16;
        step();
        chk("fill_ovf",        32'(if_overflow),       32'd1);
        chk("fill_ovf_count",  32'(if_num_data_valid), 32'd5);
        if_write = 1'b0;

        // Drain
        for (int i = 0; i < 5; i++) begin
            chk("drain_dout", 32'(if_dout), 32'(8'h11 + i));
            if_read = 1'b1;
            step();
            chk("drain_count",    32'(if_num_data_valid), 32'(4 - i));
            chk("drain_aempty_n", 32'(if_almost_empty_n), 32'((4 - i) > 1));
        end
        chk("drain_empty_n", 32'(if_empty_n), 32'd0);
        step();
        chk("drain_unf", 32'(if_underflow), 32'd1);
        if_read = 1'b0;

        // Error clear
        if_err_clr = 1'b1;
        step();
        if_err_clr = 1'b0;
        chk("clr_ovf", 32'(if_overflow),  32'd0);
        chk("clr_unf", 32'(if_underflow), 32'd0);

        // Wrap: keep two words in flight across two pointer wraps
        if_write = 1'b1; if_din = 8'h20; step();
        if_din = 8'h21; step();
        chk("wrap_pre_count", 32'(if_num_data_valid), 32'd2);
        for (int k = 0; k < 12; k++) begin
            if_write = 1'b1; if_read = 1'b1; if_din = 8'(8'h22 + k);
            chk("wrap_dout", 32'(if_dout), 32'(8'h20 + k));
            step();
            chk("wrap_count", 32'(if_num_data_valid), 32'd2);
        end
        if_write = 1'b0;
        chk("wrap_tail0", 32'(if_dout), 32'h2C);
        step();
        chk("wrap_tail1", 32'(if_dout), 32'h2D);
        step();
        if_read = 1'b0;
        chk("wrap_empty", 32'(if_empty_n), 32'd0);

        // ce gating: requests without enable do nothing
        if_write = 1'b1; if_write_ce = 1'b0; if_din = 8'h77;
        if_read = 1'b1;  if_read_ce = 1'b0;
        step();
        idle();
        chk("ce_count", 32'(if_num_data_valid), 32'd0);
        chk("ce_unf",   32'(if_underflow),      32'd0);

        // Empty with simultaneous read+write
        if_write = 1'b1; if_read = 1'b1; if_din = 8'hA5;
        step();
        idle();
        chk("bnd_empty_count", 32'(if_num_data_valid), 32'd1);
        chk("bnd_empty_dout",  32'(if_dout),           32'hA5);
        chk("bnd_empty_unf",   32'(if_underflow),      32'd1);
        if_err_clr = 1'b1; step(); if_err_clr = 1'b0;

        // Fill to full, then simultaneous read+write
        for (int i = 0; i < 4; i++) begin
            if_write = 1'b1; if_din = 8'(8'hB0 + i); step();
        end
        chk("bnd_full_count0", 32'(if_num_data_valid), 32'd5);
        if_read = 1'b1; if_din = 8'hEE;
        step();
        if_read = 1'b0;
        chk("bnd_full_count", 32'(if_num_data_valid), 32'd4);
        chk("bnd_full_ovf",   32'(if_overflow),       32'd1);
        chk("bnd_full_dout",  32'(if_dout),           32'hB0);
        if_err_clr = 1'b1; if_write = 1'b0; step();
        chk("bnd_full_clr", 32'(if_overflow), 32'd0);

        // Set beats clear when both happen together
        if_err_clr = 1'b0; if_write = 1'b1; if_din = 8'hEF; step();
        chk("setwin_count", 32'(if_num_data_valid), 32'd5);
        if_err_clr = 1'b1; step();
        chk("setwin_ovf", 32'(if_overflow), 32'd1);
        idle();

        // Drain to 3, then reset with a write pending
        chk("mid_dout", 32'(if_dout), 32'hB0);
        if_read = 1'b1; step(); step(); if_read = 1'b0;
        chk("mid_count3", 32'(if_num_data_valid), 32'd3);
        reset = 1'b1; if_write = 1'b1; if_din = 8'h99;
        step();
        reset = 1'b0; if_write = 1'b0;
        chk("mrst_count",   32'(if_num_data_valid), 32'd0);
        chk("mrst_empty_n", 32'(if_empty_n),        32'd0);
        chk("mrst_full_n",  32'(if_full_n),         32'd1);
        chk("mrst_ovf",     32'(if_overflow),       32'd0);
        chk("mrst_unf",     32'(if_underflow),      32'd0);
        if_write = 1'b1; if_din = 8'h3C; step(); if_write = 1'b0;
        chk("mrst_dout",  32'(if_dout),           32'h3C);
        chk("mrst_cnt1",  32'(if_num_data_valid), 32'd1);
        if_read = 1'b1; step(); if_read = 1'b0;
        chk("mrst_final_empty", 32'(if_empty_n), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, fail_cnt);
        $finish;
    end

endmodule
